// File: rtl/abejaruco_pkg.sv
// abejaruco_pkg: shared sizes, opcodes, ALU op classes, cache FSM states and boot image.
package abejaruco_pkg;
    localparam int WORD_WIDTH      = 32;
    localparam int CACHE_LINE_SIZE = 128;
    localparam int NUM_CACHE_LINES = 4;
    localparam int MEMORY_LATENCY  = 5;
    localparam int MEMORY_WORDS    = 4096;
    localparam int WADDR_W = $clog2(MEMORY_WORDS);
    localparam int PC_W    = WADDR_W + 2;
    localparam int WSEL_W  = $clog2(CACHE_LINE_SIZE / WORD_WIDTH);
    localparam int IDX_W   = $clog2(NUM_CACHE_LINES);
    localparam int LINE_W  = WADDR_W - WSEL_W;
    localparam int TAG_W   = LINE_W - IDX_W;
    localparam int CNT_W   = $clog2(MEMORY_LATENCY + 1);
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    typedef enum logic [1:0] {ALU_ADD_LS = 2'b00, ALU_BRANCH = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_FILL} cache_state_t;
    // Boot image: word0 = add-style R-type, word1 = 0x4, everything else zero.
    function automatic logic [WORD_WIDTH-1:0] rom_word(input logic [WADDR_W-1:0] a);
        return a == '0 ? 32'h0000_0033 : a == WADDR_W'(1) ? 32'h0000_0004 : '0;
    endfunction
endpackage

// File: rtl/abejaruco_cache.sv
// abejaruco_cache: direct-mapped instruction cache with a single outstanding miss.
//   clk, reset    : clock, async active-low reset (clears valid bits and aborts a fill)
//   i_waddr       : word address of the fetch (PC >> 2)
//   i_fill_valid  : memory line return strobe
//   i_fill_line   : returned line
//   o_data        : selected word on a hit, 0 on a miss
//   o_hit         : access hits
//   o_req         : issue a line request this cycle
//   o_req_line    : line address of the request
module abejaruco_cache
    import abejaruco_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WADDR_W-1:0]         i_waddr,
    input  logic                       i_fill_valid,
    input  logic [CACHE_LINE_SIZE-1:0] i_fill_line,
    output logic [WORD_WIDTH-1:0]      o_data,
    output logic                       o_hit,
    output logic                       o_req,
    output logic [LINE_W-1:0]          o_req_line
);
    cache_state_t               r_state, w_next;
    logic [NUM_CACHE_LINES-1:0] r_valid;
    logic [TAG_W-1:0]           r_tag  [NUM_CACHE_LINES];
    logic [CACHE_LINE_SIZE-1:0] r_line [NUM_CACHE_LINES];
    logic [IDX_W-1:0]           w_idx;
    logic [TAG_W-1:0]           w_tag;
    logic [WSEL_W-1:0]          w_wsel;
    logic [CACHE_LINE_SIZE-1:0] w_line;
    logic                       w_fill;

    assign w_idx      = i_waddr[WSEL_W +: IDX_W];
    assign w_tag      = i_waddr[WADDR_W-1 -: TAG_W];
    assign w_wsel     = i_waddr[WSEL_W-1:0];
    assign o_req_line = i_waddr[WADDR_W-1:WSEL_W];
    assign w_line     = r_line[w_idx];
    assign o_hit      = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign o_data     = o_hit ? w_line[w_wsel*WORD_WIDTH +: WORD_WIDTH] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= C_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == C_IDLE ? (o_hit ? C_IDLE : C_WAIT) :
                 r_state == C_WAIT ? (i_fill_valid ? C_FILL : C_WAIT) : C_IDLE;
    end

    always_comb begin
        o_req  = r_state == C_IDLE && !o_hit;
        w_fill = r_state == C_WAIT && i_fill_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_valid <= '0;
        else if (w_fill) r_valid[w_idx] <= 1'b1;
    end

    // The PC is frozen for the whole miss, so the current index/tag still name the line being filled.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_line[w_idx] <= i_fill_line;
        end
    end
endmodule

// File: rtl/abejaruco_control_unit.sv
// abejaruco_control_unit: combinational decode of the IF/ID opcode into an ALU op class.
//   i_opcode [6:0] : instruction opcode field
//   o_alu_op [1:0] : 10 R-type, 01 branch, 00 everything else
module abejaruco_control_unit
    import abejaruco_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [1:0] o_alu_op
);
    always_comb o_alu_op = i_opcode == OP_RTYPE  ? ALU_FUNCT  :
                           i_opcode == OP_BRANCH ? ALU_BRANCH : ALU_ADD_LS;
endmodule

// File: rtl/abejaruco_memory.sv
// abejaruco_memory: backing instruction ROM returning a whole line a fixed latency after a request.
//   clk, reset     : clock, async active-low reset (aborts an in-flight request)
//   i_req          : line request, accepted only while idle
//   i_line_addr    : line-aligned address of the request
//   o_ready        : requested line is on o_line this cycle
//   o_line         : line data, word 0 in the low bits
module abejaruco_memory
    import abejaruco_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_req,
    input  logic [LINE_W-1:0]          i_line_addr,
    output logic                       o_ready,
    output logic [CACHE_LINE_SIZE-1:0] o_line
);
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_addr;

    // Counter loads at the request edge and reaches zero MEMORY_LATENCY-1 edges later,
    // so the line is written by the cache exactly MEMORY_LATENCY edges after the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_addr <= '0;
        end else if (i_req && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(MEMORY_LATENCY - 1);
            r_addr <= i_line_addr;
        end else if (o_ready) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign o_ready = r_busy && r_cnt == '0;

    always_comb begin
        o_line = '0;
        for (int w = 0; w < CACHE_LINE_SIZE / WORD_WIDTH; w++)
            o_line[w*WORD_WIDTH +: WORD_WIDTH] = rom_word({r_addr, WSEL_W'(w)});
    end
endmodule

// File: rtl/abejaruco.sv
// abejaruco: fetch/decode bring-up top: PC, icache, backing memory, IF/ID register, control unit.
//   clk             : rising-edge clock
//   reset           : async active-low reset
//   icache_data_out : icache word at the current PC, 0 while missing
//   cu_alu_op       : ALU op class decoded from IF/ID
module abejaruco
    import abejaruco_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [WORD_WIDTH-1:0] icache_data_out,
    output logic [1:0]            cu_alu_op
);
    logic [PC_W-1:0]            r_pc;
    logic [WORD_WIDTH-1:0]      r_ifid;
    logic                       w_hit, w_req, w_fill_valid;
    logic [LINE_W-1:0]          w_req_line;
    logic [CACHE_LINE_SIZE-1:0] w_fill_line;
    logic                       w_unused;

    assign w_unused = ^r_ifid[WORD_WIDTH-1:7];

    // PC wraps naturally at the memory size; a miss reads as 0 so IF/ID gets a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= '0;
            r_ifid <= '0;
        end else begin
            r_pc   <= w_hit ? r_pc + PC_W'(4) : r_pc;
            r_ifid <= icache_data_out;
        end
    end

    abejaruco_cache u_cache (
        .clk          (clk),
        .reset        (reset),
        .i_waddr      (r_pc[PC_W-1:2]),
        .i_fill_valid (w_fill_valid),
        .i_fill_line  (w_fill_line),
        .o_data       (icache_data_out),
        .o_hit        (w_hit),
        .o_req        (w_req),
        .o_req_line   (w_req_line)
    );

    abejaruco_memory u_memory (
        .clk         (clk),
        .reset       (reset),
        .i_req       (w_req),
        .i_line_addr (w_req_line),
        .o_ready     (w_fill_valid),
        .o_line      (w_fill_line)
    );

    abejaruco_control_unit u_cu (
        .i_opcode (r_ifid[6:0]),
        .o_alu_op (cu_alu_op)
    );
endmodule

// File: tb/tb_abejaruco.sv
// tb_abejaruco: random reset stimulus against a behavioural fetch model, plus literal cold-start pins.
module tb_abejaruco;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] icache_data_out;
    logic [1:0]  cu_alu_op;

    int n_vec = 0;
    int n_bad = 0;

    abejaruco dut (
        .clk             (clk),
        .reset           (reset),
        .icache_data_out (icache_data_out),
        .cu_alu_op       (cu_alu_op)
    );

    always #5 clk = ~clk;

    // Model: byte PC, per-index tag/valid, one pending miss completing 5 edges after it is raised.
    int unsigned m_pc;
    bit          m_valid [4];
    int unsigned m_tag   [4];
    bit          m_pend;
    int          m_edge, m_fill_edge;
    logic [31:0] m_ifid;

    function automatic logic [31:0] img(int unsigned byte_addr);
        int unsigned w = (byte_addr / 4) % 4096;
        return w == 0 ? 32'h33 : w == 1 ? 32'h4 : 32'h0;
    endfunction

    function automatic bit m_hit();
        int unsigned line = m_pc / 16;
        return m_valid[line % 4] && m_tag[line % 4] == line / 4;
    endfunction

    function automatic logic [31:0] m_data();
        return m_hit() ? img(m_pc) : 32'h0;
    endfunction

    function automatic logic [1:0] m_alu();
        return m_ifid[6:0] == 7'b0110011 ? 2'b10 : m_ifid[6:0] == 7'b1100011 ? 2'b01 : 2'b00;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 0;
            m_pend = 0;
            m_edge = 0;
            m_fill_edge = 0;
            m_ifid = 0;
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 0;
                m_tag[i] = 0;
            end
        end else begin
            automatic bit          h = m_hit();
            automatic logic [31:0] d = m_data();
            m_edge++;
            if (m_pend && m_edge == m_fill_edge) begin
                m_valid[(m_pc / 16) % 4] = 1;
                m_tag[(m_pc / 16) % 4] = m_pc / 64;
                m_pend = 0;
            end else if (!m_pend && !h) begin
                m_pend = 1;
                m_fill_edge = m_edge + 5;
            end
            m_ifid = d;
            if (h) m_pc = (m_pc + 4) % 16384;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_data", icache_data_out, m_data());
        check("model_alu", {30'd0, cu_alu_op}, {30'd0, m_alu()});
    end

    task automatic edge_then(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_data", icache_data_out, 32'h0);
        check("rst_alu", {30'd0, cu_alu_op}, 32'h0);
        #5 reset = 1'b1;
        edge_then(5);
        check("cold_e5_data", icache_data_out, 32'h0);
        check("cold_e5_alu", {30'd0, cu_alu_op}, 32'h0);
        edge_then(1);
        check("cold_e6_data", icache_data_out, 32'h33);
        check("cold_e6_alu", {30'd0, cu_alu_op}, 32'h0);
        edge_then(1);
        check("cold_e7_data", icache_data_out, 32'h4);
        check("cold_e7_alu", {30'd0, cu_alu_op}, 32'h2);
        edge_then(1);
        check("cold_e8_data", icache_data_out, 32'h0);
        check("cold_e8_alu", {30'd0, cu_alu_op}, 32'h0);
        edge_then(1);
        check("cold_e9_data", icache_data_out, 32'h0);
        check("cold_e9_alu", {30'd0, cu_alu_op}, 32'h0);
        edge_then(1);
        check("pc16_miss_data", icache_data_out, 32'h0);
        // Abort a fill at edge 3 of a fresh start and confirm the full latency repeats.
        @(posedge clk) #3 reset = 1'b0;
        edge_then(2);
        check("rst_mid_data", icache_data_out, 32'h0);
        #2 reset = 1'b1;
        edge_then(3);
        #2 reset = 1'b0;
        edge_then(1);
        check("abort_data", icache_data_out, 32'h0);
        #2 reset = 1'b1;
        edge_then(5);
        check("refill_e5_data", icache_data_out, 32'h0);
        edge_then(1);
        check("refill_e6_data", icache_data_out, 32'h33);
        edge_then(1);
        check("refill_e7_alu", {30'd0, cu_alu_op}, 32'h2);
        for (int k = 0; k < 40; k++) begin
            edge_then($urandom_range(1, 60));
            #2 reset = 1'b0;
            edge_then($urandom_range(0, 2));
            #2 reset = 1'b1;
        end
        // Long run past PC wrap so line 0 is evicted and refetched.
        edge_then(10600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
